// File: rtl/register_file_8reg_pkg.sv
// register_file_8reg_pkg: shared CPU register-file constants and types
package register_file_8reg_pkg;
    localparam int REG_WIDTH = 32;
    localparam int NUM_REGS  = 8;
    localparam int REG_SEL_W = 3;
    typedef logic [REG_SEL_W-1:0] reg_sel_t;
    typedef logic [REG_WIDTH-1:0] word_t;
endpackage

// File: rtl/register_file_8reg_reg_word.sv
// reg_word: one data register with load enable and asynchronous active-high clear
module reg_word
    import register_file_8reg_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Clear immediately on reset, otherwise capture d on an enabled edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= d;
    end
endmodule

// File: rtl/register_file_8reg.sv
// register_file_8reg: 8x32 register file, one synchronous write port, two combinational read ports
module register_file_8reg
    import register_file_8reg_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int NREGS = NUM_REGS,
    parameter int SELW  = REG_SEL_W
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Input,
    input  logic [SELW-1:0]  seti,
    input  logic             WR,
    input  logic [SELW-1:0]  seto1,
    input  logic [SELW-1:0]  seto2,
    output logic [WIDTH-1:0] Output1,
    output logic [WIDTH-1:0] Output2
);
    logic [NREGS-1:0] ld;
    logic [WIDTH-1:0] regs [NREGS];

    // Decode the write select into one-hot load enables, all low unless WR
    always_comb ld = WR ? NREGS'(1) << seti : '0;

    for (genvar i = 0; i < NREGS; i++) begin : g_word
        reg_word #(.WIDTH(WIDTH)) u_word (
            .clk(clk),
            .rst(reset),
            .ld (ld[i]),
            .d  (Input),
            .q  (regs[i])
        );
    end

    // Two independent read muxes; no bypass, so a write shows only after its edge
    always_comb begin
        Output1 = regs[seto1];
        Output2 = regs[seto2];
    end
endmodule

// File: tb/tb_register_file_8reg.sv
// tb_register_file_8reg: table-driven scoreboard bench for register_file_8reg
module tb_register_file_8reg;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Input;
    logic [2:0]  seti;
    logic        WR;
    logic [2:0]  seto1;
    logic [2:0]  seto2;
    logic [31:0] Output1;
    logic [31:0] Output2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  si;
        logic [31:0] din;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] q1;
        logic [31:0] q2;
    } vec_t;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    register_file_8reg dut (
        .clk    (clk),
        .reset  (reset),
        .Input  (Input),
        .seti   (seti),
        .WR     (WR),
        .seto1  (seto1),
        .seto2  (seto2),
        .Output1(Output1),
        .Output2(Output2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] r, input logic [31:0] v);
        @(negedge clk);
        WR = 1'b1; seti = r; Input = v;
        @(posedge clk);
        #1 WR = 1'b0;
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; WR = 1'b0; Input = 32'd567; seti = 3'd0; seto1 = 3'd5; seto2 = 3'd6;
        #1;
        chk("reset_out1", Output1, 32'd0);
        chk("reset_out2", Output2, 32'd0);

        vecs.push_back('{1'b0, 3'd0, 32'd567, 3'd1, 3'd2, 32'd0, 32'd0, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 3'd3, 32'd567, 3'd4, 3'd5, 32'd0, 32'd0, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 3'd6, 32'd567, 3'd7, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 3'd7, 32'd567, 3'd3, 3'd6, 32'd0, 32'd0, 32'd0, 32'd0});
        vecs.push_back('{1'b1, 3'd0, 32'd567, 3'd3, 3'd0, 32'd0, 32'd0, 32'd0, 32'd567});
        vecs.push_back('{1'b1, 3'd2, 32'd567, 3'd2, 3'd3, 32'd0, 32'd0, 32'd567, 32'd0});
        vecs.push_back('{1'b1, 3'd5, 32'd567, 3'd5, 3'd0, 32'd0, 32'd567, 32'd567, 32'd567});
        vecs.push_back('{1'b1, 3'd7, 32'hDEADBEEF, 3'd5, 3'd7, 32'd567, 32'd0, 32'd567, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 3'd0, 32'd0, 3'd7, 3'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 3'd4, 32'h1234, 3'd4, 3'd4, 32'd0, 32'd0, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 3'd4, 32'h1234, 3'd4, 3'd0, 32'd0, 32'd567, 32'd0, 32'd567});
        vecs.push_back('{1'b0, 3'd4, 32'h1234, 3'd3, 3'd4, 32'd0, 32'd0, 32'd0, 32'd0});
        vecs.push_back('{1'b1, 3'd2, 32'hA5A5A5A5, 3'd2, 3'd0, 32'd567, 32'd567, 32'hA5A5A5A5, 32'd567});
        vecs.push_back('{1'b1, 3'd1, 32'hFFFFFFFF, 3'd1, 3'd2, 32'd0, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'hA5A5A5A5});
        vecs.push_back('{1'b0, 3'd1, 32'd0, 3'd1, 3'd7, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = 1'b0;
            WR = vecs[i].wr; seti = vecs[i].si; Input = vecs[i].din;
            seto1 = vecs[i].s1; seto2 = vecs[i].s2;
            #1;
            chk($sformatf("v%0d_pre1", i), Output1, vecs[i].p1);
            chk($sformatf("v%0d_pre2", i), Output2, vecs[i].p2);
            sb.push_back('{vecs[i].q1, vecs[i].q2, i});
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_post1", e.idx), Output1, e.e1);
                chk($sformatf("v%0d_post2", e.idx), Output2, e.e2);
            end
        end

        @(negedge clk);
        WR = 1'b0; seto1 = 3'd7; seto2 = 3'd0;
        #1;
        chk("preload_r7", Output1, 32'hDEADBEEF);
        chk("preload_r0", Output2, 32'd567);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_out1", Output1, 32'd0);
        chk("async_rst_out2", Output2, 32'd0);
        WR = 1'b1; seti = 3'd3; Input = 32'h0BADF00D;
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++) begin
            seto1 = 3'(r); seto2 = 3'(7 - r);
            #1;
            chk($sformatf("rst_hold_r%0d", r), Output1, 32'd0);
            chk($sformatf("rst_hold_r%0d_p2", 7 - r), Output2, 32'd0);
        end
        @(negedge clk);
        WR = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++) begin
            seto1 = 3'(r); seto2 = 3'(r);
            #1;
            chk($sformatf("post_rst_r%0d", r), Output1, 32'd0);
            chk($sformatf("post_rst_r%0d_p2", r), Output2, 32'd0);
        end

        write_reg(3'd6, 32'h55AA33CC);
        write_reg(3'd0, 32'h00000001);
        seto1 = 3'd6; seto2 = 3'd0;
        #1;
        chk("after_rst_w6", Output1, 32'h55AA33CC);
        chk("after_rst_w0", Output2, 32'h00000001);
        seto1 = 3'd3;
        #1;
        chk("ignored_rst_write_r3", Output1, 32'd0);

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
